// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: sign-magnitude front end, 2x2 vedic
// sub-products, one recursive combine level per stage, valid/ready handshake.
`timescale 1ns/1ps
module vedic_mult_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);
  localparam int unsigned LAT = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned DW  = WIDTH * WIDTH;

  // Each stage holds a flat grid of partial products: entry (i,j) is
  // a_chunk[i] * b_chunk[j] at slot i*n+j. S0 stores {|b|,|a|} in the low bits.
  logic [LAT-1:0][DW-1:0] data_q, data_d;
  logic [LAT-1:0]         v_q, v_d;
  logic [LAT-1:0]         neg_q, neg_d;
  logic [PW-1:0]          p_q, p_d;
  logic                   out_valid_q, out_valid_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [DW-1:0]    last_grid;
  logic [PW-1:0]    final_mag, final_p;
  logic             adv;

  function automatic logic [DW-1:0] level1(input logic [DW-1:0] ops);
    logic [WIDTH-1:0] ma, mb;
    logic [DW-1:0]    res;
    logic [1:0]       x, y;
    logic [3:0]       pp;
    logic             c;
    ma  = ops[WIDTH-1:0];
    mb  = ops[2*WIDTH-1:WIDTH];
    res = '0;
    for (int unsigned i = 0; i < WIDTH/2; i++) begin
      for (int unsigned j = 0; j < WIDTH/2; j++) begin
        x     = ma[2*i +: 2];
        y     = mb[2*j +: 2];
        pp[0] = x[0] & y[0];
        pp[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c     = x[1] & y[0] & x[0] & y[1];
        pp[2] = (x[1] & y[1]) ^ c;
        pp[3] = x[1] & y[1] & c;
        res[(i*(WIDTH/2)+j)*4 +: 4] = pp;
      end
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] combine(input logic [DW-1:0] src, input int unsigned k);
    int unsigned   h, ipw, opw, n, m;
    logic [PW-1:0] mask, pl, pm1, pm2, ph, s;
    logic [DW-1:0] res;
    h    = 1 << (k - 1);
    ipw  = 2 * h;
    opw  = 4 * h;
    n    = WIDTH >> k;
    m    = 2 * n;
    mask = (PW'(1) << ipw) - PW'(1);
    res  = '0;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = 0; j < n; j++) begin
        pl  = PW'(src >> (((2*i)*m   + 2*j)*ipw))   & mask;
        pm1 = PW'(src >> (((2*i+1)*m + 2*j)*ipw))   & mask;
        pm2 = PW'(src >> (((2*i)*m   + 2*j+1)*ipw)) & mask;
        ph  = PW'(src >> (((2*i+1)*m + 2*j+1)*ipw)) & mask;
        s   = pl + ((pm1 + pm2) << h) + (ph << (2*h));
        res = res | (DW'(s) << ((i*n+j)*opw));
      end
    end
    return res;
  endfunction

  assign adv = !(out_valid_q && !out_ready);

  always_comb begin
    v_d         = v_q;
    neg_d       = neg_q;
    data_d      = data_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;

    mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b = (sgn && b[WIDTH-1]) ? -b : b;

    if (LAT == 1) last_grid = level1(data_q[0]);
    else          last_grid = combine(data_q[LAT-1], LAT);
    final_mag = last_grid[PW-1:0];
    final_p   = neg_q[LAT-1] ? -final_mag : final_mag;

    if (adv) begin
      v_d[0]    = in_valid;
      neg_d[0]  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      data_d[0] = DW'({mag_b, mag_a});
      for (int unsigned k = 1; k < LAT; k++) begin
        v_d[k]    = v_q[k-1];
        neg_d[k]  = neg_q[k-1];
        data_d[k] = (k == 1) ? level1(data_q[0]) : combine(data_q[k-1], k);
      end
      out_valid_d = v_q[LAT-1];
      // p only moves when a real result arrives, so it keeps the last product
      if (v_q[LAT-1]) p_d = final_p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      v_q         <= '0;
      neg_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      v_q         <= v_d;
      neg_q       <= neg_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign busy      = |v_q;
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench for vedic_mult_pipe: WIDTH=8 directed/random/stall/reset
// scenarios plus exhaustive sweeps of WIDTH=4 and WIDTH=2 instances.
`timescale 1ns/1ps
module tb_vedic_mult_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // WIDTH=8 instance
  logic        rst8 = 1'b1;
  logic        iv8, ir8, sg8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  vedic_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sgn(sg8),
    .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8));

  // WIDTH=4 and WIDTH=2 instances share a separate reset
  logic        rst_s = 1'b1;
  logic        iv4, ir4, sg4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  vedic_mult_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst_s), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .sgn(sg4),
    .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4));

  logic        iv2, ir2, sg2, ov2, or2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;
  vedic_mult_pipe #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst_s), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .sgn(sg2),
    .out_valid(ov2), .out_ready(or2), .p(p2), .busy(busy2));

  logic [63:0] q8[$], q4[$], q2[$];
  int          pop_cyc8[$];
  int          cnt4 = 0, cnt2 = 0;
  logic        done4 = 1'b0, done2 = 1'b0;
  logic        rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: result 0x%0h presented with no outstanding request", name, act);
  endtask

  // Reference: plain integer multiply of the interpreted operands, truncated to 2w bits
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint      ex, ey;
    logic [63:0] r;
    ex = longint'(x);
    ey = longint'(y);
    if (s && x[w-1]) ex = ex - (longint'(1) << w);
    if (s && y[w-1]) ey = ey - (longint'(1) << w);
    r = 64'(ex * ey);
    if (w < 32) r = r & ((64'd1 << (2*w)) - 64'd1);
    return r;
  endfunction

  // Scoreboards: push on input transfer, pop/compare on output transfer
  always @(negedge clk) begin
    if (!rst8) begin
      if (iv8 && ir8) q8.push_back(ref_mul(8, 32'(a8), 32'(b8), sg8));
      if (ov8 && or8) begin
        if (q8.size() == 0) unexpected("unexpected_out8", 64'(p8));
        else begin
          check("p8", 64'(p8), q8.pop_front());
          pop_cyc8.push_back(cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_s) begin
      if (iv4 && ir4) q4.push_back(ref_mul(4, 32'(a4), 32'(b4), sg4));
      if (ov4 && or4) begin
        if (q4.size() == 0) unexpected("unexpected_out4", 64'(p4));
        else begin check("p4", 64'(p4), q4.pop_front()); cnt4++; end
      end
      if (iv2 && ir2) q2.push_back(ref_mul(2, 32'(a2), 32'(b2), sg2));
      if (ov2 && or2) begin
        if (q2.size() == 0) unexpected("unexpected_out2", 64'(p2));
        else begin check("p2", 64'(p2), q2.pop_front()); cnt2++; end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) or8 = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s);
    bit acc = 1'b0;
    iv8 = 1'b1; a8 = x; b8 = y; sg8 = s;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = ir8;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = (q8.size() == 0) && !ov8 && !busy8;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results still outstanding, required 0", q8.size());
    end
  endtask

  // Called at #1 after the accepting edge; returns cycles to out_valid and busy-high samples
  task automatic measure(output int lat, output int bc);
    lat = -1;
    bc  = busy8 ? 1 : 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (busy8) bc++;
      if (ov8 && lat < 0) lat = n;
    end
  endtask

  // Exhaustive sweeps, one pair per cycle, consumer always ready
  initial begin
    iv4 = 1'b0; a4 = '0; b4 = '0; sg4 = 1'b0; or4 = 1'b1;
    wait (rst_s == 1'b0);
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          iv4 = 1'b1; a4 = 4'(x); b4 = 4'(y); sg4 = 1'(s);
          @(posedge clk); #1;
        end
    iv4 = 1'b0;
    done4 = 1'b1;
  end

  initial begin
    iv2 = 1'b0; a2 = '0; b2 = '0; sg2 = 1'b0; or2 = 1'b1;
    wait (rst_s == 1'b0);
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++) begin
          iv2 = 1'b1; a2 = 2'(x); b2 = 2'(y); sg2 = 1'(s);
          @(posedge clk); #1;
        end
    iv2 = 1'b0;
    done2 = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bc, stale, span;
    bit fin;
    iv8 = 1'b0; a8 = '0; b8 = '0; sg8 = 1'b0; or8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ov8), 64'd0);
    check("rst_p", 64'(p8), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_in_ready", 64'(ir8), 64'd1);
    rst8 = 1'b0; rst_s = 1'b0;
    @(posedge clk); #1;

    // Single unsigned max-value product: latency and busy window
    send(8'hFF, 8'hFF, 1'b0);
    iv8 = 1'b0;
    measure(lat, bc);
    check("latency", 64'(lat), 64'd3);
    check("busy_cycles", 64'(bc), 64'd3);
    wait_drain();

    // Signed corner cases back to back
    send(8'h80, 8'h80, 1'b1);
    send(8'h80, 8'h7F, 1'b1);
    send(8'hFD, 8'h05, 1'b1);
    iv8 = 1'b0;
    wait_drain();

    // 16-pair stream with the consumer always ready
    pop_cyc8.delete();
    for (int i = 0; i < 16; i++) send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    iv8 = 1'b0;
    wait_drain();
    check("stream_count", 64'(pop_cyc8.size()), 64'd16);
    span = (pop_cyc8.size() == 16) ? pop_cyc8[15] - pop_cyc8[0] : -1;
    check("stream_span", 64'(span), 64'd15);

    // Stall: consumer not ready while the source keeps offering
    or8 = 1'b0;
    pop_cyc8.delete();
    for (int i = 0; i < 8; i++) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    check("held_entries", 64'(q8.size()), 64'd4);
    check("stall_in_ready", 64'(ir8), 64'd0);
    check("stall_out_valid", 64'(ov8), 64'd1);
    check("stall_busy", 64'(busy8), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_p_hold", 64'(p8), (q8.size() > 0) ? q8[0] : 64'hDEAD);
    or8 = 1'b1;
    wait_drain();
    check("drain_count", 64'(pop_cyc8.size()), 64'd4);

    // Reset with three entries in flight
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    iv8 = 1'b0;
    check("pre_rst_busy", 64'(busy8), 64'd1);
    rst8 = 1'b1;
    q8.delete();
    #1;
    check("mid_rst_out_valid", 64'(ov8), 64'd0);
    check("mid_rst_p", 64'(p8), 64'd0);
    check("mid_rst_busy", 64'(busy8), 64'd0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ov8) stale++;
    end
    check("no_stale_result", 64'(stale), 64'd0);
    send(8'h9C, 8'h37, 1'b1);
    iv8 = 1'b0;
    measure(lat, bc);
    check("post_rst_latency", 64'(lat), 64'd3);
    wait_drain();

    // Random traffic against a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    iv8 = 1'b0;
    rand_ready = 1'b0;
    or8 = 1'b1;
    wait_drain();

    // Wait for the exhaustive sweeps to finish draining
    fin = 1'b0;
    for (int n = 0; n < 2000 && !fin; n++) begin
      @(posedge clk); #1;
      fin = done4 && done2 && (q4.size() == 0) && (q2.size() == 0) && !ov4 && !ov2;
    end
    check("sweep4_count", 64'(cnt4), 64'd512);
    check("sweep2_count", 64'(cnt2), 64'd32);
    check("sweep4_busy_idle", 64'(busy4), 64'd0);
    check("sweep2_busy_idle", 64'(busy2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
